// File: rtl/mux_pkg.sv
// Shared definitions for the N-to-1 channel multiplexer/arbiter.
// Optional feature macro used by the design files: MUX_LOCK_EN.
package mux_pkg;

  // Selection modes
  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_e;

  // Default configuration
  localparam int MUX_DEF_NUM_CH = 4;
  localparam int MUX_DEF_DATA_W = 8;

  // Upper bound on channel count handled by the rotating search
  localparam int MUX_MAX_CH = 32;
  localparam int MUX_IDX_W  = 5;

  // Result of a rotating search: whether anything was found, and where
  typedef struct packed {
    logic                 found;
    logic [MUX_IDX_W-1:0] idx;
  } rr_pick_t;

  // Rotating first-set search: starting at last+1 and wrapping modulo n,
  // return the first set bit of req. Bits at or above n are ignored.
  function automatic rr_pick_t rr_first_set(
    input logic [MUX_MAX_CH-1:0] req,
    input int unsigned           n,
    input logic [MUX_IDX_W-1:0]  last
  );
    rr_pick_t    res;
    int unsigned k;
    res.found = 1'b0;
    res.idx   = '0;
    for (int unsigned i = 1; i <= MUX_MAX_CH; i++) begin
      if (i <= n) begin
        k = 32'(last) + i;
        if (k >= n) begin
          k = k - n;
        end
        if (!res.found && req[k[MUX_IDX_W-1:0]]) begin
          res.found = 1'b1;
          res.idx   = k[MUX_IDX_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arb_nto1.sv
// Combinational round-robin arbiter: picks the first requesting channel
// after the previously granted one, wrapping at NUM_CH.
// NUM_CH must not exceed mux_pkg::MUX_MAX_CH.
module rr_arb_nto1
  import mux_pkg::*;
#(
  parameter int NUM_CH = MUX_DEF_NUM_CH,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [SEL_W-1:0]  i_last_g,
  input  logic              i_en,
  output logic              o_grant_valid,
  output logic [SEL_W-1:0]  o_grant
);

  rr_pick_t w_pick;

  // Rotating priority search starting just after the last grant
  always_comb begin
    w_pick        = rr_first_set(MUX_MAX_CH'(i_req), NUM_CH, MUX_IDX_W'(i_last_g));
    o_grant_valid = i_en && w_pick.found;
    o_grant       = SEL_W'(w_pick.idx);
  end

endmodule

// File: rtl/mux_arb_nto1.sv
// N-to-1 channel multiplexer with registered output and valid/ready
// handshakes. Fixed-select or round-robin channel choice.
// Optional feature macro: MUX_LOCK_EN (packet lock via in_last/out_last).
module mux_arb_nto1
  import mux_pkg::*;
#(
  parameter int NUM_CH = MUX_DEF_NUM_CH,
  parameter int DATA_W = MUX_DEF_DATA_W,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
`ifdef MUX_LOCK_EN
  input  logic [NUM_CH-1:0]        in_last,
  output logic                     out_last,
`endif
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         out_ch
);

  // Vectors are padded to the full index range so that a select index at
  // or above NUM_CH reads a defined zero rather than falling off the end.
  localparam int              PAD_CH   = 1 << SEL_W;
  localparam logic [SEL_W:0]  NUM_CH_W = (SEL_W+1)'(NUM_CH);

  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic [SEL_W-1:0]  r_out_ch;
  logic [SEL_W-1:0]  r_last_g;
`ifdef MUX_LOCK_EN
  logic              r_out_last;
  logic              r_locked;
  logic [SEL_W-1:0]  r_lock_ch;
  logic [PAD_CH-1:0] w_last_pad;
`endif

  logic [PAD_CH-1:0] w_valid_pad;
  logic              w_load;
  logic              w_sel_ok;
  logic              w_fix_valid;
  logic              w_arb_en;
  logic              w_arb_valid;
  logic [SEL_W-1:0]  w_arb_grant;
  logic              w_grant_valid;
  logic [SEL_W-1:0]  w_grant;
  logic              w_xfer;
  logic [DATA_W-1:0] w_data;

  assign w_valid_pad = PAD_CH'(in_valid);
`ifdef MUX_LOCK_EN
  assign w_last_pad  = PAD_CH'(in_last);
`endif

  // The output register may accept a new word when empty or draining
  assign w_load = !r_out_valid || out_ready;

  // Fixed-mode grant only for an in-range, valid channel
  assign w_sel_ok    = {1'b0, sel} < NUM_CH_W;
  assign w_fix_valid = w_sel_ok && w_valid_pad[sel];

`ifdef MUX_LOCK_EN
  assign w_arb_en = (mode == MODE_RR) && !r_locked;
`else
  assign w_arb_en = (mode == MODE_RR);
`endif

  rr_arb_nto1 #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_rr_arb (
    .i_req         (in_valid),
    .i_last_g      (r_last_g),
    .i_en          (w_arb_en),
    .o_grant_valid (w_arb_valid),
    .o_grant       (w_arb_grant)
  );

  // Choose the granted channel for this cycle from the active mode
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant       = '0;
    if (mode == MODE_FIXED) begin
      w_grant_valid = w_fix_valid;
      w_grant       = sel;
    end else begin
`ifdef MUX_LOCK_EN
      if (r_locked) begin
        w_grant_valid = w_valid_pad[r_lock_ch];
        w_grant       = r_lock_ch;
      end else begin
        w_grant_valid = w_arb_valid;
        w_grant       = w_arb_grant;
      end
`else
      w_grant_valid = w_arb_valid;
      w_grant       = w_arb_grant;
`endif
    end
  end

  // A transfer happens whenever the granted channel is offered ready
  assign w_xfer = rst_n && w_load && w_grant_valid;

  // Ready goes only to the granted channel; nothing is accepted in reset
  always_comb begin
    in_ready = '0;
    if (w_xfer) begin
      in_ready = NUM_CH'(1) << w_grant;
    end
  end

  // Pick the granted channel's data word
  always_comb begin
    w_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_grant == SEL_W'(k)) begin
        w_data = in_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Output register, round-robin pointer and packet lock state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_last_g    <= SEL_W'(NUM_CH - 1);
`ifdef MUX_LOCK_EN
      r_out_last  <= 1'b0;
      r_locked    <= 1'b0;
      r_lock_ch   <= '0;
`endif
    end else begin
      if (w_load) begin
        if (w_xfer) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_data;
          r_out_ch    <= w_grant;
          r_last_g    <= w_grant;
`ifdef MUX_LOCK_EN
          r_out_last  <= w_last_pad[w_grant];
`endif
        end else begin
          r_out_valid <= 1'b0;
        end
      end
`ifdef MUX_LOCK_EN
      if (mode == MODE_FIXED) begin
        r_locked <= 1'b0;
      end else if (w_xfer) begin
        r_locked  <= !w_last_pad[w_grant];
        r_lock_ch <= w_grant;
      end
`endif
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;
`ifdef MUX_LOCK_EN
  assign out_last  = r_out_last;
`endif

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Self-checking bench for mux_arb_nto1: a 4-channel instance checked
// against a behavioural model, plus a 3-channel instance for the
// out-of-range select case. Lock scenario built when MUX_LOCK_EN is set.
module tb_mux_arb_nto1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // 4-channel instance stimulus
  logic [31:0] in_data4  = '0;
  logic [3:0]  in_valid4 = '0;
  logic [3:0]  in_ready4;
  logic [3:0]  in_last4  = '0;
  logic        mode4     = 1'b0;
  logic [1:0]  sel4      = '0;
  logic [7:0]  out_data4;
  logic        out_valid4;
  logic        out_ready4 = 1'b0;
  logic [1:0]  out_ch4;
  logic        out_last4;

  // 3-channel instance stimulus
  logic [23:0] in_data3  = '0;
  logic [2:0]  in_valid3 = '0;
  logic [2:0]  in_ready3;
  logic [2:0]  in_last3  = '0;
  logic        mode3     = 1'b0;
  logic [1:0]  sel3      = '0;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic        out_ready3 = 1'b0;
  logic [1:0]  out_ch3;
  logic        out_last3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mux_arb_nto1 #(.NUM_CH(4), .DATA_W(8)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data4),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
`ifdef MUX_LOCK_EN
    .in_last   (in_last4),
    .out_last  (out_last4),
`endif
    .mode      (mode4),
    .sel       (sel4),
    .out_data  (out_data4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out_ch    (out_ch4)
  );

  mux_arb_nto1 #(.NUM_CH(3), .DATA_W(8)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
`ifdef MUX_LOCK_EN
    .in_last   (in_last3),
    .out_last  (out_last3),
`endif
    .mode      (mode3),
    .sel       (sel3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_ch    (out_ch3)
  );

`ifndef MUX_LOCK_EN
  assign out_last4 = 1'b0;
  assign out_last3 = 1'b0;
`endif

  // Behavioural model of the 4-channel instance
  bit       m_valid = 1'b0;
  bit [7:0] m_data = '0;
  int       m_ch = 0;
  int       m_last = 3;
  bit       m_olast = 1'b0;
  bit       m_locked = 1'b0;
  int       m_lock_ch = 0;

  // Which channel the rules say should be granted right now
  function automatic void model_grant(output bit found, output int idx);
    found = 1'b0;
    idx = 0;
    if (mode4 == 1'b0) begin
      idx = int'(sel4);
      found = (idx < 4) && in_valid4[idx];
    end else if (m_locked) begin
      idx = m_lock_ch;
      found = in_valid4[idx];
    end else begin
      for (int off = 1; off <= 4; off++) begin
        if (!found && in_valid4[(m_last + off) % 4]) begin
          found = 1'b1;
          idx = (m_last + off) % 4;
        end
      end
    end
  endfunction

  function automatic logic [3:0] model_ready();
    bit f;
    int g;
    model_grant(f, g);
    if (rst_n && (!m_valid || out_ready4) && f) return 4'(1 << g);
    return 4'b0000;
  endfunction

  always @(posedge clk) begin : model_step
    bit f;
    int g;
    model_grant(f, g);
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data <= '0;
      m_ch <= 0;
      m_last <= 3;
      m_olast <= 1'b0;
      m_locked <= 1'b0;
      m_lock_ch <= 0;
    end else begin
      if (!m_valid || out_ready4) begin
        if (f) begin
          m_valid <= 1'b1;
          m_data <= in_data4[g*8 +: 8];
          m_ch <= g;
          m_last <= g;
`ifdef MUX_LOCK_EN
          m_olast <= in_last4[g];
          if (mode4) begin
            m_locked <= !in_last4[g];
            m_lock_ch <= g;
          end
`endif
        end else begin
          m_valid <= 1'b0;
        end
      end
      if (!mode4) m_locked <= 1'b0;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mode4 = 1'b1;
    in_valid4 = 4'b1111;
    in_data4 = 32'hDEADBEEF;
    out_ready4 = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (in_ready4 !== 4'b0000) begin
        miscompares++;
        $display("[TB] FAIL reset_in_ready: got %b want 0000", in_ready4);
      end
      vectors++;
      if (out_valid4 !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid4);
      end
      vectors++;
      if (out_data4 !== 8'h00 || out_ch4 !== 2'd0) begin
        miscompares++;
        $display("[TB] FAIL reset_out_data_ch: got %h/%0d want 00/0", out_data4, out_ch4);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fixed();
    mode4 = 1'b0;
    sel4 = 2'd2;
    in_data4 = 32'h33A51100;
    in_valid4 = 4'b1111;
    out_ready4 = 1'b1;
    #1;
    vectors++;
    if (in_ready4 !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL fixed_in_ready: got %b want 0100", in_ready4);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid4 !== 1'b1 || out_data4 !== 8'hA5 || out_ch4 !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL fixed_output: got v=%b d=%h ch=%0d want v=1 d=a5 ch=2",
               out_valid4, out_data4, out_ch4);
    end
  endtask

  task automatic test_rr();
    do_reset();
    mode4 = 1'b1;
    in_data4 = 32'h13121110;
    in_valid4 = 4'b1111;
    out_ready4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (in_ready4 !== 4'(1 << (i % 4))) begin
        miscompares++;
        $display("[TB] FAIL rr_in_ready[%0d]: got %b want %b", i, in_ready4, 4'(1 << (i % 4)));
      end
      @(posedge clk);
      #1;
      vectors++;
      if (out_valid4 !== 1'b1 || out_ch4 !== 2'(i % 4) || out_data4 !== 8'(8'h10 + i % 4)) begin
        miscompares++;
        $display("[TB] FAIL rr_output[%0d]: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                 i, out_valid4, out_ch4, out_data4, i % 4, 8'(8'h10 + i % 4));
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready4 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (in_ready4 !== 4'b0000) begin
        miscompares++;
        $display("[TB] FAIL stall_in_ready[%0d]: got %b want 0000", c, in_ready4);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (out_valid4 !== 1'b1 || out_data4 !== 8'h10 || out_ch4 !== 2'd0) begin
        miscompares++;
        $display("[TB] FAIL stall_hold[%0d]: got v=%b d=%h ch=%0d want v=1 d=10 ch=0",
                 c, out_valid4, out_data4, out_ch4);
      end
    end
    out_ready4 = 1'b1;
    #1;
    vectors++;
    if (in_ready4 !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL resume_in_ready: got %b want 0010", in_ready4);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid4 !== 1'b1 || out_data4 !== 8'h11 || out_ch4 !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL resume_output: got v=%b d=%h ch=%0d want v=1 d=11 ch=1",
               out_valid4, out_data4, out_ch4);
    end
  endtask

  task automatic test_sel_out_of_range();
    mode3 = 1'b0;
    sel3 = 2'd1;
    in_data3 = 24'h332211;
    in_valid3 = 3'b111;
    out_ready3 = 1'b0;
    #1;
    vectors++;
    if (in_ready3 !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL n3_load_in_ready: got %b want 010", in_ready3);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid3 !== 1'b1 || out_data3 !== 8'h22 || out_ch3 !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL n3_load_output: got v=%b d=%h ch=%0d want v=1 d=22 ch=1",
               out_valid3, out_data3, out_ch3);
    end
    sel3 = 2'd3;
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid3 !== 1'b1 || out_data3 !== 8'h22) begin
      miscompares++;
      $display("[TB] FAIL n3_stall_hold: got v=%b d=%h want v=1 d=22", out_valid3, out_data3);
    end
    out_ready3 = 1'b1;
    #1;
    vectors++;
    if (in_ready3 !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL n3_sel3_in_ready: got %b want 000", in_ready3);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid3 !== 1'b0 || out_data3 !== 8'h22 || out_ch3 !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL n3_drain: got v=%b d=%h ch=%0d want v=0 d=22 ch=1",
               out_valid3, out_data3, out_ch3);
    end
    in_valid3 = 3'b000;
    out_ready3 = 1'b0;
  endtask

`ifdef MUX_LOCK_EN
  task automatic test_lock();
    logic [3:0] vld  [5] = '{4'b0010, 4'b0111, 4'b0101, 4'b0111, 4'b0111};
    logic [3:0] lst  [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
    logic [3:0] rdy  [5] = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0100};
    logic       ov   [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0] och  [5] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    logic       olst [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    mode4 = 1'b1;
    in_data4 = 32'h44332211;
    out_ready4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid4 = vld[i];
      in_last4 = lst[i];
      #1;
      vectors++;
      if (in_ready4 !== rdy[i]) begin
        miscompares++;
        $display("[TB] FAIL lock_in_ready[%0d]: got %b want %b", i, in_ready4, rdy[i]);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (out_valid4 !== ov[i] || out_ch4 !== och[i] || out_last4 !== olst[i]) begin
        miscompares++;
        $display("[TB] FAIL lock_output[%0d]: got v=%b ch=%0d last=%b want v=%b ch=%0d last=%b",
                 i, out_valid4, out_ch4, out_last4, ov[i], och[i], olst[i]);
      end
    end
    in_last4 = '0;
  endtask
`endif

  task automatic test_random();
    logic [3:0] exp_rdy;
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 9) == 0) mode4 = ~mode4;
      sel4 = 2'($urandom);
      in_valid4 = 4'($urandom);
      in_data4 = $urandom;
      in_last4 = 4'($urandom);
      out_ready4 = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = model_ready();
      vectors++;
      if (in_ready4 !== exp_rdy) begin
        miscompares++;
        $display("[TB] FAIL rand_in_ready[%0d]: got %b want %b", c, in_ready4, exp_rdy);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (out_valid4 !== m_valid || out_data4 !== m_data || out_ch4 !== 2'(m_ch)) begin
        miscompares++;
        $display("[TB] FAIL rand_output[%0d]: got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d",
                 c, out_valid4, out_data4, out_ch4, m_valid, m_data, m_ch);
      end
`ifdef MUX_LOCK_EN
      vectors++;
      if (out_last4 !== m_olast) begin
        miscompares++;
        $display("[TB] FAIL rand_out_last[%0d]: got %b want %b", c, out_last4, m_olast);
      end
`endif
    end
    rst_n = 1'b1;
  endtask

  initial begin
    $display("[TB] starting mux_arb_nto1 bench");
    test_reset();
    test_fixed();
    test_rr();
    test_backpressure();
    test_sel_out_of_range();
`ifdef MUX_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_arb_nto1.md
Name: mux_arb_nto1

Overview:
Parametrised N-to-1 channel multiplexer with a registered output stage and valid/ready handshakes on every input and on the output. It is the sequential successor to the combinational 4:1 mux. Two selection modes: fixed, where an external sel chooses the channel, and round-robin arbitration across valid channels. It sits between several producer channels and a single downstream consumer.

Parameters:
NUM_CH, 4, number of input channels (>=2; need not be a power of two)
DATA_W, 8, data width per channel
SEL_W, $clog2(NUM_CH), width of sel/out_ch (derived; do not override)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
in_data  in  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
in_valid  in  NUM_CH  per-channel valid
in_ready  out  NUM_CH  per-channel ready (one-hot or zero)
mode  in  1  0 = fixed select, 1 = round-robin
sel  in  SEL_W  channel index used in fixed mode
out_data  out  DATA_W  registered output data
out_valid  out  1  registered output valid
out_ready  in  1  downstream ready
out_ch  out  SEL_W  index of the channel that supplied out_data

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, out_ch=0, RR pointer last_g=NUM_CH-1, so channel 0 has first priority.
- load = !out_valid || out_ready (single output register, no skid buffer).
- Grant (combinational):
  - mode=0: g=sel if sel<NUM_CH and in_valid[sel]; otherwise no grant.
  - mode=1: g = first k with in_valid[k], searching from last_g+1 upward and wrapping modulo NUM_CH; no grant if all in_valid=0.
- in_ready[g] = load && grant. All other in_ready bits are 0. No combinational path from in_valid[k] to in_ready[k] for non-granted k.
- Input transfer: in_valid[g] && in_ready[g].
- On an input transfer: out_data<=in_data[g], out_ch<=g, out_valid<=1, last_g<=g. last_g updates in both modes.
- If load and no grant: out_valid<=0. out_data and out_ch hold their values.
- If !load (out_valid=1, out_ready=0): all output registers hold and in_ready=0.
- Latency is 1 cycle from input transfer to out_valid. Full throughput is one beat per cycle while out_ready=1.
- Fairness: in RR mode with all channels valid, grants cycle 0,1,...,NUM_CH-1,0 with no repeats until every channel has been served.
- Mode or sel changes take effect on the next arbitration. A word already held in the output register is unaffected.
- sel>=NUM_CH (non-power-of-two NUM_CH): treated as no grant, never an X select.
- Reset mid-operation discards the held word (out_valid=0 on the following cycle).

Optional Feature:
Macro MUX_LOCK_EN.
- Defined:
  - Adds port in_last (in, NUM_CH) and port out_last (out, 1, reset 0, registered with out_data).
  - In mode=1, once channel g transfers a beat with in_last[g]=0, the grant stays locked to g until a beat with in_last[g]=1 transfers. While locked, other channels get no grant even if g deasserts valid.
  - In mode=0 the lock is ignored. Switching mode clears the lock.
- Not defined: no in_last/out_last ports; arbitration is per beat.

Decomposition:
- Shared package mux_pkg holds:
  - mode encodings MODE_FIXED=1'b0 and MODE_RR=1'b1;
  - the default NUM_CH and DATA_W constants;
  - a function for the rotating first-set search.
- One natural sub-module: rr_arb_nto1 (NUM_CH). Inputs: req vector, last_g, en. Outputs: grant_valid and grant index. The top keeps the output register, handshake and lock logic.

Test Plan:
1. Reset with NUM_CH=4, DATA_W=8, all inputs valid -> out_valid=0, out_data=0, out_ch=0, in_ready=0 while rst_n=0.
2. mode=0, sel=2, in_data ch2=0xA5, all valid, out_ready=1 -> next cycle out_data=0xA5, out_ch=2; in_ready=4'b0100 only.
3. mode=1, all valid, data ch0..3=0x10,0x11,0x12,0x13 -> out_ch sequence 0,1,2,3,0 on consecutive cycles; data matches.
4. mode=1, out_valid=1, out_ready=0 for 3 cycles -> out_data stable, in_ready=0000; on out_ready=1, next grant resumes from last_g+1.
5. NUM_CH=3, mode=0, sel=3 -> no grant, in_ready=000, out_valid falls to 0 after draining.
6. MUX_LOCK_EN: ch1 sends 3 beats (in_last on beat 3) while ch0/ch2 are valid -> out_ch=1,1,1, then 2; out_last=1 only on the third beat.
